lsu_bus_master: RTL and testbench

- Initiator side of the data-memory interface: takes one load/store per request from the MEM pipeline stage and drives a req/ack word bus to an external data memory or bridge.
- Generates byte enables and lane-aligned write data for stores. Extracts and sign- or zero-extends read data for loads.
- Stalls the pipeline until the bus transaction completes.
- Flags misaligned addresses (AdEL/AdES) and bus timeouts.

---
 rtl/lsu_bus_master_pkg.sv | 75 +++++++
 rtl/lsu_bus_master_load_align.sv | 30 +++
 rtl/lsu_bus_master.sv | 134 +++++++++++++
 tb/tb_lsu_bus_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the LSU bus master: op encodings, FSM states and
// helpers for alignment, byte-enable and write-lane generation.
package lsu_bus_master_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LBU = 3'd1,
    LSU_LH  = 3'd2,
    LSU_LHU = 3'd3,
    LSU_LW  = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  // Access size code: 0 = byte, 1 = half, 2 = word
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic op_is_load(input logic [2:0] op);
    return (op <= LSU_LW);
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    logic [1:0] sz;
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: sz = SZ_BYTE;
      LSU_LH, LSU_LHU, LSU_SH: sz = SZ_HALF;
      default:                 sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Bytes are always aligned; halves need an even address; words need a
  // multiple of four.
  function automatic logic addr_aligned(input logic [2:0] op, input logic [1:0] off);
    logic ok;
    case (op_size(op))
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] gen_be(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] be;
    case (op_size(op))
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-justified store data across every lane so the
  // responder can pick the lane(s) selected by the byte enables.
  function automatic logic [31:0] gen_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] d;
    case (op_size(op))
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_bus_master_load_align.sv
// Lane select and sign/zero extension of a full bus word into a load result.
// Purely combinational so it can be shared with other read paths.
module lsu_bus_master_load_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  op_type,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the op
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    rdata    = 32'd0;
    case (op_type)
      LSU_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: rdata = {24'd0, byte_sel};
      LSU_LH:  rdata = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: rdata = {16'd0, half_sel};
      LSU_LW:  rdata = word;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Data-memory bus initiator for the MEM stage. One load/store per request,
// req/ack handshake, misalignment detection and a REQ-state timeout.
//
// Handshake: bus_req rises on the edge that accepts an aligned op and stays
// high, with all bus_* fields stable, until the first cycle in which
// bus_ack=1 is sampled (or the timeout expires); bus_ack is ignored whenever
// bus_req=0. The transaction then spends exactly one DONE cycle reporting
// its result before returning to IDLE.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state;
  lsu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [1:0]       off_q;

  logic             in_aligned;
  logic             in_load;
  logic             accept;
  logic             misalign;
  logic             ack_hit;
  logic             timeout_hit;
  logic [31:0]      load_word;

  assign in_aligned = addr_aligned(op_type, addr[1:0]);
  assign in_load    = op_is_load(op_type);

  lsu_bus_master_load_align u_load_align (
    .op_type (op_q),
    .offset  (off_q),
    .word    (bus_rdata),
    .rdata   (load_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; ack takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (op_valid && in_aligned) state_nxt = S_REQ;
      S_REQ:   if (bus_ack || cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded events and the combinational stall
  always_comb begin
    accept      = (state == S_IDLE) && op_valid && in_aligned;
    misalign    = (state == S_IDLE) && op_valid && !in_aligned;
    ack_hit     = (state == S_REQ) && bus_ack;
    timeout_hit = (state == S_REQ) && !bus_ack && (cnt == CNT_LAST);
    stall       = accept || (state == S_REQ);
  end

  // Registered datapath: bus fields, timeout counter, result and pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_be      <= 4'd0;
      bus_wdata   <= 32'd0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      adel        <= 1'b0;
      ades        <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      adel        <= misalign && in_load;
      ades        <= misalign && !in_load;
      rdata_valid <= ack_hit && op_is_load(op_q);
      bus_err     <= timeout_hit;

      if (accept) begin
        cnt       <= '0;
        op_q      <= op_type;
        off_q     <= addr[1:0];
        bus_req   <= 1'b1;
        bus_we    <= !in_load;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= gen_be(op_type, addr[1:0]);
        bus_wdata <= in_load ? 32'd0 : gen_wdata(op_type, wdata);
      end else if (ack_hit || timeout_hit) begin
        bus_req   <= 1'b0;
        bus_we    <= 1'b0;
        bus_addr  <= 32'd0;
        bus_be    <= 4'd0;
        bus_wdata <= 32'd0;
      end else if (state == S_REQ) begin
        cnt <= cnt + 1'b1;
      end

      if (ack_hit)          rdata <= op_is_load(op_q) ? load_word : 32'd0;
      else if (timeout_hit) rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases followed by random
// ops, checked against a size/offset arithmetic reference model.
module tb_lsu_bus_master;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        adel;
  logic        ades;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  lsu_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_type     (op_type),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .adel        (adel),
    .ades        (ades),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
    return 4;
  endfunction

  function automatic bit ref_is_load(input logic [2:0] op);
    return op < 3'd5;
  endfunction

  function automatic bit ref_aligned(input logic [2:0] op, input logic [31:0] a);
    return (a % ref_size(op)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] a);
    int sz = ref_size(op);
    int mask = (1 << sz) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r = 32'd0;
    int sz = ref_size(op);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    int sz = ref_size(op);
    bit sgn = (op == 3'd0 || op == 3'd2);
    logic [31:0] m;
    logic [31:0] v;
    if (sz == 4) return w;
    m = (32'd1 << (8*sz)) - 32'd1;
    v = (w >> (8 * (a % 4))) & m;
    if (sgn && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // ack_at: REQ cycle index (0-based) on which bus_ack is raised; <0 = never
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] word);
    bit ld = ref_is_load(op);
    bit al = ref_aligned(op, a);
    bit acked = (ack_at >= 0) && (ack_at < TIMEOUT);
    int n_req = acked ? ack_at + 1 : TIMEOUT;

    op_valid = 1'b1; op_type = op; addr = a; wdata = wd; bus_ack = 1'b0;
    #1;
    chk("stall_on_offer", 32'(stall), 32'(al));

    if (!al) begin
      tick();
      op_valid = 1'b0;
      #1;
      chk("adel_pulse", 32'(adel), 32'(ld));
      chk("ades_pulse", 32'(ades), 32'(!ld));
      chk("misalign_no_req", 32'(bus_req), 32'd0);
      chk("misalign_no_stall", 32'(stall), 32'd0);
      tick();
      chk("adel_clear", 32'(adel), 32'd0);
      chk("ades_clear", 32'(ades), 32'd0);
      chk("misalign_still_no_req", 32'(bus_req), 32'd0);
      return;
    end

    tick();
    for (int i = 0; i < n_req; i++) begin
      chk("req_high", 32'(bus_req), 32'd1);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_we", 32'(bus_we), 32'(!ld));
      chk("req_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_be", 32'(bus_be), 32'(ref_be(op, a)));
      if (!ld) chk("req_wdata", bus_wdata, ref_wdata(op, wd));
      bus_ack   = (i == ack_at);
      bus_rdata = (i == ack_at) ? word : 32'($urandom);
      tick();
      bus_ack = 1'b0;
    end

    // DONE cycle
    chk("done_req_low", 32'(bus_req), 32'd0);
    chk("done_stall_low", 32'(stall), 32'd0);
    chk("done_be_clear", 32'(bus_be), 32'd0);
    chk("done_addr_clear", bus_addr, 32'd0);
    chk("done_rvalid", 32'(rdata_valid), 32'(ld && acked));
    chk("done_bus_err", 32'(bus_err), 32'(!acked));
    if (ld && acked) chk("done_rdata", rdata, ref_load(op, a, word));
    if (!acked) chk("timeout_rdata_zero", rdata, 32'd0);

    // op_valid still present during DONE must not start a second transfer
    tick();
    chk("no_reissue", 32'(bus_req), 32'd0);
    chk("rvalid_one_cycle", 32'(rdata_valid), 32'd0);
    chk("bus_err_one_cycle", 32'(bus_err), 32'd0);
    op_valid = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; op_valid = 1'b0; op_type = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) tick();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_pulses", {28'd0, rdata_valid, adel, ades, bus_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Directed cases
    run_op(3'd4, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);        // LW
    run_op(3'd5, 32'h0000_0203, 32'h0000_00A5, 0, 32'd0);        // SB lane 3
    run_op(3'd0, 32'h0000_0001, 32'd0, 0, 32'h1234_8000);        // LB
    run_op(3'd1, 32'h0000_0001, 32'd0, 0, 32'h1234_8000);        // LBU
    run_op(3'd2, 32'h0000_0002, 32'd0, 1, 32'h8001_7FFF);        // LH
    run_op(3'd3, 32'h0000_0002, 32'd0, 2, 32'h8001_7FFF);        // LHU
    run_op(3'd6, 32'h0000_0010, 32'h1234_CAFE, 0, 32'd0);        // SH low half
    run_op(3'd7, 32'h0000_0020, 32'h0BAD_F00D, 3, 32'd0);        // SW
    run_op(3'd4, 32'h0000_0102, 32'd0, 0, 32'd0);                // LW misaligned
    run_op(3'd6, 32'h0000_0005, 32'd0, 0, 32'd0);                // SH misaligned
    run_op(3'd7, 32'h0000_0300, 32'h5555_AAAA, -1, 32'd0);       // SW timeout
    run_op(3'd4, 32'h0000_0400, 32'd0, TIMEOUT - 1, 32'hC0DE_0001); // ack on last cycle

    // Reset in the middle of a REQ phase, then a late ack
    op_valid = 1'b1; op_type = 3'd7; addr = 32'h0000_0040; wdata = 32'h1111_2222;
    #1;
    chk("rstmid_stall_offer", 32'(stall), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_req_high", 32'(bus_req), 32'd1);
      tick();
    end
    reset = 1'b0; op_valid = 1'b0;
    tick();
    chk("rstmid_req_dropped", 32'(bus_req), 32'd0);
    chk("rstmid_stall_low", 32'(stall), 32'd0);
    chk("rstmid_be_clear", 32'(bus_be), 32'd0);
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    chk("late_ack_no_req", 32'(bus_req), 32'd0);
    chk("late_ack_no_rvalid", 32'(rdata_valid), 32'd0);
    chk("late_ack_no_err", 32'(bus_err), 32'd0);
    tick();
    chk("late_ack_quiet", {29'd0, rdata_valid, bus_err, bus_req}, 32'd0);

    // Random ops
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  r_op   = 3'($urandom_range(0, 7));
      logic [31:0] r_addr = $urandom;
      logic [31:0] r_wd   = $urandom;
      logic [31:0] r_word = $urandom;
      int          r_ack  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_op(r_op, r_addr, r_wd, r_ack, r_word);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends on its own
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
